// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle control sequencer for a LEGv8 subset
// (ADDI, ADDS, SUBS, LDUR, STUR). It accepts one instruction word from a
// valid/ready requester, decodes it on the accept edge, walks the
// DECODE/EXEC/[MEM]/WB states and drives registered datapath controls,
// register and immediate fields, done/illegal pulses and a retired counter.
module instr_sequencer #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    input  logic [31:0]        instr,
    output logic               instr_ready,
    output logic               reg2Loc,
    output logic               regWrite,
    output logic               memWrite,
    output logic               flagEn,
    output logic [1:0]         aluSrc,
    output logic [1:0]         memToReg,
    output logic [2:0]         aluOp,
    output logic [4:0]         Rd,
    output logic [4:0]         Rm,
    output logic [4:0]         Rn,
    output logic [8:0]         Imm9,
    output logic [11:0]        Imm12,
    output logic               done,
    output logic               illegal,
    output logic [COUNT_W-1:0] retired_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_e;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_ADDI,
        OP_ADDS,
        OP_SUBS,
        OP_LDUR,
        OP_STUR
    } op_e;

    // Mux selects and ALU operation, held constant for a whole instruction.
    typedef struct packed {
        logic       reg2loc;
        logic [1:0] alu_src;
        logic [1:0] mem_to_reg;
        logic [2:0] alu_op;
    } sel_t;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;

    state_e             state_q;
    op_e                op_q;
    op_e                op_d;
    sel_t               sel_q;
    sel_t               sel_d;
    logic [21:0]        field_q;     // only bits [21:0] carry register/immediate fields
    logic               reg_write_q;
    logic               mem_write_q;
    logic               flag_en_q;
    logic               done_q;
    logic               illegal_q;
    logic [COUNT_W-1:0] count_q;
    logic               accept;
    logic               is_mem_op;

    // Classify the word on the input bus so its controls are registered on the accept edge.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
        op_d  = OP_NONE;
        sel_d = '0;
        if (instr[31:22] == 10'b1001000100) begin
            op_d = OP_ADDI;
        end else if (instr[31:21] == 11'b10101011000) begin
            op_d = OP_ADDS;
        end else if (instr[31:21] == 11'b11101011000) begin
            op_d = OP_SUBS;
        end else if (instr[31:21] == 11'b11111000010) begin
            op_d = OP_LDUR;
        end else if (instr[31:21] == 11'b11111000000) begin
            op_d = OP_STUR;
        end
        case (op_d)
            OP_ADDI: begin
                sel_d.alu_src = 2'b10;
                sel_d.alu_op  = ALU_ADD;
            end
            OP_ADDS: begin
                sel_d.reg2loc = 1'b1;
                sel_d.alu_op  = ALU_ADD;
            end
            OP_SUBS: begin
                sel_d.reg2loc = 1'b1;
                sel_d.alu_op  = ALU_SUB;
            end
            OP_LDUR: begin
                sel_d.alu_src    = 2'b01;
                sel_d.mem_to_reg = 2'b01;
                sel_d.alu_op     = ALU_ADD;
            end
            OP_STUR: begin
                sel_d.alu_src = 2'b01;
                sel_d.alu_op  = ALU_ADD;
            end
            default: sel_d = '0;
        endcase
    end

    // Ready only in IDLE and never while reset is held low.
    assign instr_ready = (state_q == S_IDLE) && reset;
    assign accept      = instr_valid && instr_ready;
    assign is_mem_op   = (op_q == OP_LDUR) || (op_q == OP_STUR);

    // Sequencer FSM: state, latched fields, registered strobes and retired counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // NOTE: the asynchronous clear drops every strobe at once, so a write pending in MEM is simply abandoned.
            state_q     <= S_IDLE;
            op_q        <= OP_NONE;
            sel_q       <= '0;
            field_q     <= '0;
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
            flag_en_q   <= 1'b0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
            count_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments only; pulses default low here and a later assignment below wins.
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
            flag_en_q   <= 1'b0;
            done_q      <= 1'b0;
            illegal_q   <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_q   <= S_DECODE;
                        op_q      <= op_d;
                        sel_q     <= sel_d;
                        field_q   <= instr[21:0];
                        illegal_q <= (op_d == OP_NONE);
                    end
                end
                S_DECODE: begin
                    if (op_q == OP_NONE) begin
                        state_q <= S_IDLE;
                        op_q    <= OP_NONE;
                        sel_q   <= '0;
                        field_q <= '0;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_mem_op) begin
                        state_q     <= S_MEM;
                        mem_write_q <= (op_q == OP_STUR);
                    end else begin
                        state_q     <= S_WB;
                        done_q      <= 1'b1;
                        reg_write_q <= 1'b1;
                        flag_en_q   <= 1'b1;
                        count_q     <= count_q + COUNT_W'(1);
                    end
                end
                S_MEM: begin
                    state_q     <= S_WB;
                    done_q      <= 1'b1;
                    reg_write_q <= (op_q == OP_LDUR);
                    count_q     <= count_q + COUNT_W'(1);
                end
                S_WB: begin
                    state_q <= S_IDLE;
                    op_q    <= OP_NONE;
                    sel_q   <= '0;
                    field_q <= '0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign reg2Loc       = sel_q.reg2loc;
    assign aluSrc        = sel_q.alu_src;
    assign memToReg      = sel_q.mem_to_reg;
    assign aluOp         = sel_q.alu_op;
    assign regWrite      = reg_write_q;
    assign memWrite      = mem_write_q;
    // EXEC raises flag_en_q for every ALU op; only ADDS/SUBS may update flags.
    assign flagEn        = flag_en_q && sel_q.reg2loc;
    assign done          = done_q;
    assign illegal       = illegal_q;
    assign Rd            = field_q[4:0];
    assign Rn            = field_q[9:5];
    assign Rm            = field_q[20:16];
    assign Imm9          = field_q[20:12];
    assign Imm12         = field_q[21:10];
    assign retired_count = count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Testbench for instr_sequencer: directed LEGv8 words plus randomized
// instruction streams, checked cycle by cycle against a reference model
// that derives each cycle's outputs from the instruction class and the
// cycle index within the instruction.
module tb_instr_sequencer;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          instr_valid = 1'b0;
    logic [31:0]   instr = '0;
    logic          instr_ready;
    logic          reg2Loc, regWrite, memWrite, flagEn;
    logic [1:0]    aluSrc, memToReg;
    logic [2:0]    aluOp;
    logic [4:0]    Rd, Rm, Rn;
    logic [8:0]    Imm9;
    logic [11:0]   Imm12;
    logic          done, illegal;
    logic [CW-1:0] retired_count;

    int tests_run = 0;
    int tests_failed = 0;
    int model_count = 0;

    instr_sequencer #(.COUNT_W(CW)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .reg2Loc(reg2Loc), .regWrite(regWrite),
        .memWrite(memWrite), .flagEn(flagEn), .aluSrc(aluSrc), .memToReg(memToReg),
        .aluOp(aluOp), .Rd(Rd), .Rm(Rm), .Rn(Rn), .Imm9(Imm9), .Imm12(Imm12),
        .done(done), .illegal(illegal), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    typedef enum {M_ADDI, M_ADDS, M_SUBS, M_LDUR, M_STUR, M_BAD} mnem_e;

    typedef struct packed {
        logic        ready;
        logic        reg2loc;
        logic        reg_write;
        logic        mem_write;
        logic        flag_en;
        logic [1:0]  alu_src;
        logic [1:0]  mem_to_reg;
        logic [2:0]  alu_op;
        logic [4:0]  rd;
        logic [4:0]  rm;
        logic [4:0]  rn;
        logic [8:0]  imm9;
        logic [11:0] imm12;
        logic        done;
        logic        illegal;
    } obs_t;

    localparam logic [31:0] W_ADDI = 32'h91000BE1;  // ADDI X1,X31,#2
    localparam logic [31:0] W_SUBS = 32'hEB020023;  // SUBS X3,X1,X2
    localparam logic [31:0] W_ADDS = 32'hAB020023;  // ADDS X3,X1,X2
    localparam logic [31:0] W_STUR = 32'hF8006022;  // STUR X2,[X1,#6]
    localparam logic [31:0] W_LDUR = 32'hF8406025;  // LDUR X5,[X1,#6]

    function automatic mnem_e classify(input logic [31:0] w);
        if (w[31:22] == 10'b1001000100)  return M_ADDI;
        if (w[31:21] == 11'b10101011000) return M_ADDS;
        if (w[31:21] == 11'b11101011000) return M_SUBS;
        if (w[31:21] == 11'b11111000010) return M_LDUR;
        if (w[31:21] == 11'b11111000000) return M_STUR;
        return M_BAD;
    endfunction

    // Cycles from the accept edge until the instruction is finished (done or illegal).
    function automatic int latency(input mnem_e m);
        case (m)
            M_BAD:          return 1;
            M_LDUR, M_STUR: return 4;
            default:        return 3;
        endcase
    endfunction

    // Expected outputs in cycle k after accept (k=0 means an idle cycle out of reset).
    function automatic obs_t model(input logic [31:0] w, input int k);
        obs_t  e;
        mnem_e m;
        int    n;
        e = '0;
        if (k == 0) begin
            e.ready = 1'b1;
            return e;
        end
        m = classify(w);
        n = latency(m);
        e.rd    = w[4:0];
        e.rn    = w[9:5];
        e.rm    = w[20:16];
        e.imm9  = w[20:12];
        e.imm12 = w[21:10];
        case (m)
            M_ADDI: begin e.alu_src = 2'b10; e.alu_op = 3'b010; end
            M_ADDS: begin e.reg2loc = 1'b1;  e.alu_op = 3'b010; end
            M_SUBS: begin e.reg2loc = 1'b1;  e.alu_op = 3'b011; end
            M_LDUR: begin e.alu_src = 2'b01; e.alu_op = 3'b010; e.mem_to_reg = 2'b01; end
            M_STUR: begin e.alu_src = 2'b01; e.alu_op = 3'b010; end
            default: e.illegal = (k == 1);
        endcase
        e.done      = (m != M_BAD) && (k == n);
        e.reg_write = e.done && (m != M_STUR);
        e.flag_en   = e.done && (m == M_ADDS || m == M_SUBS);
        e.mem_write = (m == M_STUR) && (k == 3);
        return e;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.ready      = instr_ready;
        o.reg2loc    = reg2Loc;
        o.reg_write  = regWrite;
        o.mem_write  = memWrite;
        o.flag_en    = flagEn;
        o.alu_src    = aluSrc;
        o.mem_to_reg = memToReg;
        o.alu_op     = aluOp;
        o.rd         = Rd;
        o.rm         = Rm;
        o.rn         = Rn;
        o.imm9       = Imm9;
        o.imm12      = Imm12;
        o.done       = done;
        o.illegal    = illegal;
        return o;
    endfunction

    // Called just after an accept edge: checks every busy cycle, the following idle cycle and the count.
    // hold=1 keeps instr_valid/instr steady; hold=0 scrambles them while busy.
    task automatic finish_instr(input logic [31:0] w, input bit hold, input string name);
        obs_t          got;
        obs_t          exp_o;
        logic [CW-1:0] exp_cnt;
        int            n;
        n = latency(classify(w));
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            got   = observe();
            exp_o = model(w, k);
            tests_run++;
            if (got !== exp_o) begin
                tests_failed++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, k, got, exp_o);
            end
            if (!hold) begin
                if (k < n) begin
                    instr_valid = 1'($urandom);
                    instr       = $urandom;
                end else begin
                    instr_valid = 1'b0;
                end
            end
        end
        if (classify(w) != M_BAD) model_count = (model_count + 1) % (1 << CW);
        @(negedge clk);
        got   = observe();
        exp_o = model(w, 0);
        tests_run++;
        if (got !== exp_o) begin
            tests_failed++;
            $display("FAIL %s idle: got %h expected %h", name, got, exp_o);
        end
        exp_cnt = CW'(model_count);
        tests_run++;
        if (retired_count !== exp_cnt) begin
            tests_failed++;
            $display("FAIL %s count: got %0d expected %0d", name, retired_count, exp_cnt);
        end
    endtask

    // Called just after a negedge with the DUT idle: offers w and runs it to completion.
    task automatic run_instr(input logic [31:0] w, input bit hold, input string name);
        instr_valid = 1'b1;
        instr       = w;
        @(posedge clk);
        finish_instr(w, hold, name);
    endtask

    task automatic test_reset();
        obs_t got;
        obs_t exp_o;
        reset       = 1'b0;
        instr_valid = 1'b1;
        instr       = W_ADDI;
        repeat (3) @(negedge clk);
        got   = observe();
        exp_o = '0;
        tests_run++;
        if (got !== exp_o) begin
            tests_failed++;
            $display("FAIL reset_hold: got %h expected %h", got, exp_o);
        end
        tests_run++;
        if (retired_count !== '0) begin
            tests_failed++;
            $display("FAIL reset_count: got %0d expected 0", retired_count);
        end
        instr_valid = 1'b0;
        reset       = 1'b1;
        #1;
        got   = observe();
        exp_o = model('0, 0);
        tests_run++;
        if (got !== exp_o) begin
            tests_failed++;
            $display("FAIL reset_release: got %h expected %h", got, exp_o);
        end
        model_count = 0;
    endtask

    task automatic test_alu();
        run_instr(W_ADDI, 1'b0, "addi");
        run_instr(W_SUBS, 1'b0, "subs");
        run_instr(W_ADDS, 1'b0, "adds");
    endtask

    task automatic test_mem();
        run_instr(W_STUR, 1'b0, "stur");
        run_instr(W_LDUR, 1'b0, "ldur");
    endtask

    task automatic test_illegal();
        run_instr(32'h0000_0000, 1'b0, "illegal_zero");
        run_instr(32'hFFFF_FFFF, 1'b0, "illegal_ones");
    endtask

    task automatic test_random();
        logic [31:0] w;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 5))
                0:       w = {10'b1001000100, 22'($urandom)};
                1:       w = {11'b10101011000, 21'($urandom)};
                2:       w = {11'b11101011000, 21'($urandom)};
                3:       w = {11'b11111000010, 21'($urandom)};
                4:       w = {11'b11111000000, 21'($urandom)};
                default: w = $urandom;
            endcase
            run_instr(w, 1'($urandom), "random");
        end
        instr_valid = 1'b0;
    endtask

    task automatic test_reset_mid_mem();
        obs_t got;
        obs_t exp_o;
        instr_valid = 1'b1;
        instr       = W_STUR;
        @(posedge clk);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            got   = observe();
            exp_o = model(W_STUR, k);
            tests_run++;
            if (got !== exp_o) begin
                tests_failed++;
                $display("FAIL mid_mem cycle %0d: got %h expected %h", k, got, exp_o);
            end
        end
        #2 reset = 1'b0;
        #1;
        got   = observe();
        exp_o = '0;
        tests_run++;
        if (got !== exp_o) begin
            tests_failed++;
            $display("FAIL mid_mem_async: got %h expected %h", got, exp_o);
        end
        tests_run++;
        if (retired_count !== '0) begin
            tests_failed++;
            $display("FAIL mid_mem_count: got %0d expected 0", retired_count);
        end
        model_count = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        got   = observe();
        exp_o = model(W_STUR, 0);
        tests_run++;
        if (got !== exp_o) begin
            tests_failed++;
            $display("FAIL mid_mem_release: got %h expected %h", got, exp_o);
        end
        @(posedge clk);
        finish_instr(W_STUR, 1'b0, "after_reset_accept");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) begin
            run_instr(W_ADDI, 1'b1, "back_to_back");
        end
        instr_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_alu();
        test_mem();
        test_illegal();
        test_random();
        test_reset_mid_mem();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
